// File: rtl/ram_block_mover.sv
// Word-by-word RAM block copier: read src, write dst, 3 cycles per word.
// Optional fill mode (1 write per word, no reads) built with `define RAM_BLOCK_MOVER_FILL_EN.
module ram_block_mover #(
  parameter int addr_width = 16,
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  start,
  input  logic [addr_width-1:0] src,
  input  logic [addr_width-1:0] dst,
  input  logic [addr_width-1:0] len,
`ifdef RAM_BLOCK_MOVER_FILL_EN
  input  logic                  fill,
  input  logic [data_width-1:0] fill_val,
`endif
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_din,
  output logic                  ram_cs,
  output logic                  ram_oe,
  output logic                  ram_wr,
  input  logic [data_width-1:0] ram_q
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_RDW  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [addr_width-1:0] LEN_ZERO = '0;
  localparam logic [addr_width-1:0] LEN_ONE  = addr_width'(1);

  logic [2:0]            state_q, state_d;
  logic [addr_width-1:0] src_q, src_d;
  logic [addr_width-1:0] dst_q, dst_d;
  logic [addr_width-1:0] rem_q, rem_d;
  logic [data_width-1:0] data_q, data_d;
  logic                  fill_active;
  logic                  fill_req;
  logic [data_width-1:0] fill_data;

`ifdef RAM_BLOCK_MOVER_FILL_EN
  logic fill_q, fill_d;

  assign fill_active = fill_q;
  assign fill_req    = fill;
  assign fill_data   = fill_val;
`else
  assign fill_active = 1'b0;
  assign fill_req    = 1'b0;
  assign fill_data   = '0;
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    data_d  = data_q;
`ifdef RAM_BLOCK_MOVER_FILL_EN
    fill_d  = fill_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d = src;
          dst_d = dst;
          rem_d = len;
`ifdef RAM_BLOCK_MOVER_FILL_EN
          fill_d = fill;
`endif
          // In fill mode the data register simply holds the fill value for every write.
          if (fill_req) data_d = fill_data;
          if (len == LEN_ZERO)  state_d = S_FIN;
          else if (fill_req)    state_d = S_WR;
          else                  state_d = S_RD;
        end
      end
      S_RD: begin
        state_d = abort ? S_IDLE : S_RDW;
      end
      S_RDW: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          data_d  = ram_q;
          state_d = S_WR;
        end
      end
      S_WR: begin
        src_d = src_q + LEN_ONE;
        dst_d = dst_q + LEN_ONE;
        rem_d = rem_q - LEN_ONE;
        if (abort)                 state_d = S_IDLE;
        else if (rem_q == LEN_ONE) state_d = S_FIN;
        else if (fill_active)      state_d = S_WR;
        else                       state_d = S_RD;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
`ifdef RAM_BLOCK_MOVER_FILL_EN
      fill_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
`ifdef RAM_BLOCK_MOVER_FILL_EN
      fill_q  <= fill_d;
`endif
    end
  end

  // Outputs decode straight from the state register so reset clears them immediately.
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_FIN);
    ram_cs   = (state_q == S_RD) || (state_q == S_RDW) || (state_q == S_WR);
    ram_oe   = (state_q == S_RD) || (state_q == S_RDW);
    ram_wr   = (state_q == S_WR);
    ram_addr = '0;
    ram_din  = '0;
    if (state_q == S_WR) begin
      ram_addr = dst_q;
      ram_din  = data_q;
    end else if (ram_oe) begin
      ram_addr = src_q;
    end
  end

endmodule

// File: tb/tb_ram_block_mover.sv
// Bench for ram_block_mover: behavioural RAM, per-cycle expected-output queue model,
// and directed transfers. Define RAM_BLOCK_MOVER_FILL_EN to also exercise fill mode.
module tb_ram_block_mover;
  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          resetb, start, abort;
  logic [AW-1:0] src, dst, len;
  logic          busy, done, ram_cs, ram_oe, ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_q;
`ifdef RAM_BLOCK_MOVER_FILL_EN
  logic          fill;
  logic [DW-1:0] fill_val;
`endif

  always #5 clk = ~clk;

  ram_block_mover #(.addr_width(AW), .data_width(DW)) dut (
    .clk(clk), .resetb(resetb), .start(start), .src(src), .dst(dst), .len(len),
`ifdef RAM_BLOCK_MOVER_FILL_EN
    .fill(fill), .fill_val(fill_val),
`endif
    .abort(abort), .busy(busy), .done(done), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_cs(ram_cs), .ram_oe(ram_oe), .ram_wr(ram_wr), .ram_q(ram_q)
  );

  // Behavioural RAM plus a bench-side preload port
  logic [DW-1:0] mem    [0:65535];
  logic [DW-1:0] refmem [0:65535];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_cs && ram_wr) mem[ram_addr] <= ram_din;
    if (ram_cs && ram_oe) ram_q <= mem[ram_addr];
    else ram_q <= 8'hEE;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            busy, done, cs, oe, wr, from_mem;
    logic [AW-1:0] addr, rsrc;
    logic [DW-1:0] lit;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt, done_cyc, cs_cnt, oe_cnt;
  logic [AW-1:0] rd_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Compare process: one expected entry per cycle; an empty queue means idle.
  exp_t          e;
  logic [DW-1:0] exp_din;
  bit            prev_rd;
  logic [AW-1:0] prev_addr;
  always @(negedge clk) begin
    if (pre_we) refmem[pre_addr] = pre_data;
    if (expq.size() > 0) e = expq.pop_front();
    else e = '{default: '0};
    chk("busy", busy, e.busy);
    chk("done", done, e.done);
    chk("ram_cs", ram_cs, e.cs);
    chk("ram_oe", ram_oe, e.oe);
    chk("ram_wr", ram_wr, e.wr);
    chk("oe_wr_exclusive", ram_oe & ram_wr, 0);
    if (e.cs) chk("ram_addr", ram_addr, e.addr);
    if (!e.busy || e.done) begin
      chk("idle_addr", ram_addr, 0);
      chk("idle_din", ram_din, 0);
    end
    if (e.wr) begin
      exp_din = e.from_mem ? refmem[e.rsrc] : e.lit;
      chk("ram_din", ram_din, exp_din);
      refmem[e.addr] = exp_din;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (ram_cs) cs_cnt++;
    if (ram_oe) oe_cnt++;
    if (ram_cs && ram_oe && !(prev_rd && prev_addr == ram_addr)) rd_log.push_back(ram_addr);
    prev_rd   = ram_cs && ram_oe;
    prev_addr = ram_addr;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input bit b, d, cs, oe, wr, fm, input logic [AW-1:0] a, rs,
                      input logic [DW-1:0] lit);
    exp_t x;
    x.busy = b; x.done = d; x.cs = cs; x.oe = oe; x.wr = wr; x.from_mem = fm;
    x.addr = a; x.rsrc = rs; x.lit = lit;
    expq.push_back(x);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    pre_we = 1'b1; pre_addr = a; pre_data = v;
    tick(1);
    pre_we = 1'b0;
  endtask

  // Issue a start and queue the cycle-by-cycle expectation of the full transfer.
  task automatic go(input logic [AW-1:0] s, d, l, input bit f, input logic [DW-1:0] fv,
                    output int scyc);
    logic [AW-1:0] sa, da;
    src = s; dst = d; len = l; start = 1'b1;
`ifdef RAM_BLOCK_MOVER_FILL_EN
    fill = f; fill_val = fv;
`endif
    scyc = cyc;
    done_cnt = 0; cs_cnt = 0; oe_cnt = 0;
    rd_log.delete();
    $display("xfer src=%h dst=%h len=%0d fill=%0d start_cycle=%0d", s, d, l, f, scyc);
    push(0, 0, 0, 0, 0, 0, '0, '0, '0);
    for (int i = 0; i < int'(l); i++) begin
      sa = s + AW'(i);
      da = d + AW'(i);
      if (f) begin
        push(1, 0, 1, 0, 1, 0, da, '0, fv);
      end else begin
        push(1, 0, 1, 1, 0, 0, sa, '0, '0);
        push(1, 0, 1, 1, 0, 0, sa, '0, '0);
        push(1, 0, 1, 0, 1, 1, da, sa, '0);
      end
    end
    push(1, 1, 0, 0, 0, 0, '0, '0, '0);
    tick(1);
    start = 1'b0;
  endtask

  // Abort during the current cycle: nothing after this cycle's entry happens.
  task automatic do_abort();
    abort = 1'b1;
    while (expq.size() > 1) expq.delete(expq.size() - 1);
    tick(1);
    abort = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (expq.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    chk(nm, expq.size(), 0);
    expq.delete();
    tick(1);
  endtask

  int s0;

  initial begin
    resetb = 1'b0; start = 1'b0; abort = 1'b0;
    src = '0; dst = '0; len = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
`ifdef RAM_BLOCK_MOVER_FILL_EN
    fill = 1'b0; fill_val = '0;
`endif
    tick(2);
    preload(16'h0010, 8'h11); preload(16'h0011, 8'h22);
    preload(16'h0012, 8'h33); preload(16'h0013, 8'h44);
    preload(16'hFFFE, 8'hA1); preload(16'hFFFF, 8'hB2); preload(16'h0000, 8'hC3);
    for (int i = 0; i < 8; i++) preload(16'h0030 + AW'(i), 8'h50 + DW'(i));
    preload(16'h00A2, 8'h77);
    preload(16'h0040, 8'h01); preload(16'h0041, 8'h02);
    preload(16'h0042, 8'h03); preload(16'h0043, 8'h04);
    preload(16'h00B1, 8'h66);
    chk("reset_busy", busy, 0);
    chk("reset_cs", ram_cs, 0);

    // Basic copy straight out of reset, with a start while busy that must be ignored
    resetb = 1'b1;
    go(16'h0010, 16'h0080, 16'd4, 0, '0, s0);
    tick(2);
    src = 16'h0099; dst = 16'h0099; len = 16'd1; start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_idle("copy4_timeout");
    chk("copy4_done_latency", done_cyc - s0, 13);
    chk("copy4_done_pulses", done_cnt, 1);
    chk("copy4_mem80", mem[16'h0080], 8'h11);
    chk("copy4_mem81", mem[16'h0081], 8'h22);
    chk("copy4_mem82", mem[16'h0082], 8'h33);
    chk("copy4_mem83", mem[16'h0083], 8'h44);
    chk("ignored_start_mem99", mem[16'h0099], 8'h00);

    // Zero-length transfer
    go(16'h0020, 16'h0090, 16'd0, 0, '0, s0);
    wait_idle("len0_timeout");
    chk("len0_done_latency", done_cyc - s0, 1);
    chk("len0_done_pulses", done_cnt, 1);
    chk("len0_cs_cycles", cs_cnt, 0);

    // Source pointer wraps past FFFF
    go(16'hFFFE, 16'h0100, 16'd3, 0, '0, s0);
    wait_idle("wrap_timeout");
    chk("wrap_reads", rd_log.size(), 3);
    if (rd_log.size() == 3) begin
      chk("wrap_rd0", rd_log[0], 16'hFFFE);
      chk("wrap_rd1", rd_log[1], 16'hFFFF);
      chk("wrap_rd2", rd_log[2], 16'h0000);
    end
    chk("wrap_mem100", mem[16'h0100], 8'hA1);
    chk("wrap_mem101", mem[16'h0101], 8'hB2);
    chk("wrap_mem102", mem[16'h0102], 8'hC3);
    chk("wrap_done_latency", done_cyc - s0, 10);

    // Abort in RDW of word 3 of 8
    go(16'h0030, 16'h00A0, 16'd8, 0, '0, s0);
    tick(7);
    do_abort();
    chk("abort_rdw_busy_next", busy, 0);
    wait_idle("abort_rdw_timeout");
    chk("abort_rdw_done_pulses", done_cnt, 0);
    chk("abort_rdw_memA0", mem[16'h00A0], 8'h50);
    chk("abort_rdw_memA1", mem[16'h00A1], 8'h51);
    chk("abort_rdw_memA2", mem[16'h00A2], 8'h77);

    // Overlapping regions copied strictly ascending
    go(16'h0040, 16'h0042, 16'd4, 0, '0, s0);
    wait_idle("overlap_timeout");
    chk("overlap_mem42", mem[16'h0042], 8'h01);
    chk("overlap_mem43", mem[16'h0043], 8'h02);
    chk("overlap_mem44", mem[16'h0044], 8'h01);
    chk("overlap_mem45", mem[16'h0045], 8'h02);

    // Abort in WR: that write lands, nothing more
    go(16'h0010, 16'h00B0, 16'd2, 0, '0, s0);
    tick(2);
    do_abort();
    chk("abort_wr_busy_next", busy, 0);
    wait_idle("abort_wr_timeout");
    chk("abort_wr_done_pulses", done_cnt, 0);
    chk("abort_wr_memB0", mem[16'h00B0], 8'h11);
    chk("abort_wr_memB1", mem[16'h00B1], 8'h66);

    // Abort coinciding with FIN: done still pulses
    go(16'h0011, 16'h00C0, 16'd1, 0, '0, s0);
    tick(3);
    do_abort();
    wait_idle("abort_fin_timeout");
    chk("abort_fin_done_pulses", done_cnt, 1);
    chk("abort_fin_memC0", mem[16'h00C0], 8'h22);

    // Reset in the middle of a WR
    go(16'h0010, 16'h00D0, 16'd2, 0, '0, s0);
    tick(2);
    resetb = 1'b0;
    expq.delete();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cs", ram_cs, 0);
    chk("rst_oe", ram_oe, 0);
    chk("rst_wr", ram_wr, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_din", ram_din, 0);
    tick(1);
    chk("rst_abandon_done", done_cnt, 0);
    resetb = 1'b1;
    go(16'h0012, 16'h00D8, 16'd1, 0, '0, s0);
    wait_idle("post_rst_timeout");
    chk("post_rst_done_latency", done_cyc - s0, 4);
    chk("post_rst_done_pulses", done_cnt, 1);
    chk("post_rst_memD8", mem[16'h00D8], 8'h33);

`ifdef RAM_BLOCK_MOVER_FILL_EN
    // Fill mode: one write per word, never any read
    go(16'h0000, 16'h0200, 16'd5, 1, 8'hA5, s0);
    fill = 1'b0;
    wait_idle("fill_timeout");
    chk("fill_done_latency", done_cyc - s0, 6);
    chk("fill_done_pulses", done_cnt, 1);
    chk("fill_oe_cycles", oe_cnt, 0);
    for (int i = 0; i < 5; i++) chk("fill_mem", mem[16'h0200 + AW'(i)], 8'hA5);
`endif

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_block_mover.md
RAM_BLOCK_MOVER -- requirements
Module: ram_block_mover

Interface
REQ-001 SHALL have parameter addr_width, default 16, RAM address width and transfer length width.
REQ-002 SHALL have parameter data_width, default 8, RAM data width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-004 SHALL have port resetb  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-006 SHALL have port src  input  addr_width  first source address; latched on accepted start.
REQ-007 SHALL have port dst  input  addr_width  first destination address; latched on accepted start.
REQ-008 SHALL have port len  input  addr_width  word count; latched on accepted start.
REQ-009 SHALL have port abort  input  1  stop request; honoured in any non-IDLE state.
REQ-010 SHALL have port busy  output  1  high in every non-IDLE state.
REQ-011 SHALL have port done  output  1  one-cycle pulse on normal completion.
REQ-012 SHALL have port ram_addr  output  addr_width  RAM address.
REQ-013 SHALL have port ram_din  output  data_width  RAM write data.
REQ-014 SHALL have port ram_cs, ram_oe, ram_wr  output  1 each  RAM chip select, output enable, write enable.
REQ-015 SHALL have port ram_q  input  data_width  RAM read data; valid only while cs and oe are high, one cycle after the read is issued.

Function
REQ-016 SHALL implement the FSM states IDLE, RD, RDW, WR and FIN.
REQ-017 IDLE: all ram_* outputs are 0; a start with len != 0 moves the FSM to RD; a start with len == 0 moves it to FIN without any RAM access.
REQ-018 RD: ram_addr=src_ptr, ram_cs=1, ram_oe=1, ram_wr=0; next state RDW.
REQ-019 RDW: same address and strobes as RD; on the clock edge ram_q is captured into the data register; next state WR.
REQ-020 WR: ram_addr=dst_ptr, ram_din=data register, ram_cs=1, ram_wr=1, ram_oe=0; on the clock edge src_ptr and dst_ptr increment and remaining decrements.
REQ-021 WR exits to FIN when remaining was 1 and to RD otherwise.
REQ-022 FIN: done=1 for exactly one cycle, ram_* outputs are 0; next state IDLE.
REQ-023 Throughput SHALL be 3 cycles per word in copy mode; done SHALL assert 3*len+1 cycles after the accepted start cycle.
REQ-024 Pointer increments SHALL wrap modulo 2^addr_width, e.g. FFFF+1=0000.
REQ-025 Overlapping source and destination regions SHALL be copied strictly in ascending order without any hazard handling.
REQ-026 A start arriving while busy SHALL be ignored, with no latching and no queueing.
REQ-027 abort in RD or RDW SHALL return the FSM to IDLE next cycle with no write issued.
REQ-028 abort in WR SHALL let that write complete on the edge, then go to IDLE.
REQ-029 After any abort, done SHALL NOT pulse.
REQ-030 When abort and FIN coincide, FIN wins and done pulses.
REQ-031 ram_wr and ram_oe SHALL never both be high in the same cycle.

Reset
REQ-032 Asserting resetb low SHALL immediately force IDLE, clear busy, done and all ram_* outputs, and clear the pointers, count and data register.
REQ-033 Reset mid-transfer SHALL abandon the transfer with no done pulse; a write in progress may not complete.
REQ-034 After resetb deasserts, the block SHALL accept start on the first rising edge.

Configuration
REQ-035 Macro RAM_BLOCK_MOVER_FILL_EN SHALL compile in the fill feature.
REQ-036 With RAM_BLOCK_MOVER_FILL_EN defined, the block SHALL add inputs fill (1 bit) and fill_val (data_width bits), both latched on start.
REQ-037 With the macro defined and fill=1, the FSM SHALL skip RD and RDW, write fill_val to each destination, take 1 cycle per word, assert done len+1 cycles after start, and never assert ram_oe.
REQ-038 Without the macro, the fill and fill_val ports SHALL NOT exist and the block SHALL operate in copy mode only.

Verification
REQ-039 RAM preloaded mem[0x10..0x13]=11,22,33,44; start src=0x10, dst=0x80, len=4 -> mem[0x80..0x83]=11,22,33,44, done at cycle 13, exactly one pulse.
REQ-040 start with len=0 -> done the cycle after FIN entry, ram_cs never high.
REQ-041 start src=0xFFFE, dst=0x0100, len=3 -> reads 0xFFFE, 0xFFFF, 0x0000 (wrap verified).
REQ-042 abort asserted in the RDW of word 3 of 8 -> exactly 2 words written, busy low next cycle, no done pulse.
REQ-043 resetb pulsed low mid-WR -> all outputs 0 immediately; a subsequent start len=1 completes normally.
REQ-044 With FILL_EN defined, fill=1, fill_val=0xA5, dst=0x200, len=5 -> mem[0x200..0x204]=A5, done at cycle 6, ram_oe never high.
